// File: rtl/if_sequencer.sv
// Instruction-fetch sequencer: one prioritised decision per cycle (branch > stall > jr/j > exception > irq),
// plus the pending-exception latch, post-trap irq holdoff and a sticky runaway-stall watchdog.
module if_sequencer #(
  parameter int unsigned HOLDOFF   = 3,
  parameter int unsigned STALL_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       branch_taken,
  input  logic       jump_id,
  input  logic       jr_id,
  input  logic       jr_hazard,
  input  logic       load_use_hazard,
  input  logic       irq,
  input  logic       exception,
  input  logic       kernel_mode,
  output logic       PC_IF_ID_Write,
  output logic [2:0] select_PC_next,
  output logic [1:0] status,
  output logic       irq_ack,
  output logic       exc_pending,
  output logic       stall_timeout
);

  localparam logic [3:0] HOLDOFF_LD = 4'(HOLDOFF);
  localparam logic [7:0] STALL_LAST = 8'(STALL_MAX - 1);

  logic       exc_pending_q, exc_pending_d;
  logic [3:0] holdoff_q, holdoff_d;
  logic [7:0] stall_cnt_q, stall_cnt_d;
  logic       stall_timeout_q, stall_timeout_d;

  logic stall_cyc, redirect, exc_take, irq_take;

  always_comb begin
    stall_cyc = ~branch_taken & (load_use_hazard | (jr_id & jr_hazard));
    redirect  = branch_taken | stall_cyc | jr_id | jump_id;
    exc_take  = ~redirect & (exc_pending_q | exception);
    irq_take  = ~redirect & ~exc_take & irq & ~kernel_mode & (holdoff_q == 4'd0);
  end

  // Outputs are held quiet while reset is asserted, independent of the inputs.
  always_comb begin
    PC_IF_ID_Write = 1'b0;
    select_PC_next = 3'b000;
    status         = 2'b00;
    irq_ack        = 1'b0;
    if (rst_n) begin
      PC_IF_ID_Write = ~stall_cyc;
      if (branch_taken)      select_PC_next = 3'b100;
      else if (stall_cyc)    select_PC_next = 3'b000;
      else if (jr_id)        select_PC_next = 3'b001;
      else if (jump_id)      select_PC_next = 3'b010;
      status  = {irq_take, exc_take};
      irq_ack = irq_take;
    end
  end

  always_comb begin
    exc_pending_d = exc_take ? 1'b0 : (exc_pending_q | exception);

    if (exc_take | irq_take)     holdoff_d = HOLDOFF_LD;
    else if (holdoff_q != 4'd0)  holdoff_d = holdoff_q - 4'd1;
    else                         holdoff_d = holdoff_q;

    if (!stall_cyc)                 stall_cnt_d = 8'd0;
    else if (stall_cnt_q == 8'hFF)  stall_cnt_d = stall_cnt_q;
    else                            stall_cnt_d = stall_cnt_q + 8'd1;

    stall_timeout_d = stall_timeout_q | (stall_cyc & (stall_cnt_q == STALL_LAST));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exc_pending_q   <= 1'b0;
      holdoff_q       <= 4'd0;
      stall_cnt_q     <= 8'd0;
      stall_timeout_q <= 1'b0;
    end else begin
      exc_pending_q   <= exc_pending_d;
      holdoff_q       <= holdoff_d;
      stall_cnt_q     <= stall_cnt_d;
      stall_timeout_q <= stall_timeout_d;
    end
  end

  assign exc_pending   = exc_pending_q;
  assign stall_timeout = stall_timeout_q;

endmodule

// File: doc/if_sequencer.md
# if_sequencer

Per-cycle controller for the instruction-fetch stage. It arbitrates between branch, jump, jr, load-use stall, exception and interrupt events, and drives the fetch stage's PC/IF_ID write enable, the one-hot next-PC select and the trap status. It also holds exceptions pending until they can be taken, blocks interrupt re-entry for a programmable window, and watches for runaway stalls. It sits beside the fetch stage and takes inputs from the hazard unit, ID decode, EX branch resolution and the interrupt/exception sources.

## Interface
- HOLDOFF, 3: cycles after a trap during which irq is ignored; legal range 1..15.
- STALL_MAX, 15: consecutive stall cycles at which stall_timeout is raised; legal range 1..255.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- branch_taken  in  1  EX has resolved a taken branch this cycle.
- jump_id  in  1  ID holds a j instruction.
- jr_id  in  1  ID holds a jr instruction.
- jr_hazard  in  1  jr source register is not yet forwardable.
- load_use_hazard  in  1  load-use hazard detected this cycle.
- irq  in  1  interrupt request, level-sensitive.
- exception  in  1  exception event, single-cycle pulse.
- kernel_mode  in  1  bit 31 of the PC currently being fetched.
- PC_IF_ID_Write  out  1  enable for PC and IF_ID update.
- select_PC_next  out  3  {Z, J, JR}, one-hot or 000.
- status  out  2  {interrupt, exception}.
- irq_ack  out  1  one-cycle pulse when an interrupt is taken.
- exc_pending  out  1  exception latched, not yet taken.
- stall_timeout  out  1  sticky watchdog flag.

## Operation
- Outputs are combinational from the inputs and registered state. State consists of exc_pending, holdoff_cnt[3:0], stall_cnt[7:0] and stall_timeout.
- Each cycle exactly one decision is made, evaluated in this priority order:
  1. branch_taken: write=1, select=100, status=00. Pending events are kept.
  2. stall = load_use_hazard | (jr_id & jr_hazard): write=0, select=000, status=00. select must be 000 so the fetch stage does not flush the held instruction.
  3. jr_id: write=1, select=001. Else jump_id: write=1, select=010. If both are high, jr wins.
  4. exc_take = exc_pending | exception: write=1, select=000, status=01. Clears exc_pending and loads holdoff_cnt=HOLDOFF.
  5. irq_take = irq & ~kernel_mode & (holdoff_cnt==0): write=1, status=10, irq_ack=1. Loads holdoff_cnt=HOLDOFF.
  6. Otherwise: write=1, select=000, status=00.
- Exception latch:
  - An exception pulse that is not taken in its own cycle (case 1, 2 or 3 won) sets exc_pending.
  - exc_pending stays set until an exc_take cycle.
  - A second pulse while pending is merged; there is no count.
- irq is never latched. It is re-evaluated every cycle and an unserviced irq simply waits.
- holdoff_cnt decrements by 1 every cycle while nonzero, stalls included. A load takes precedence over the decrement.
- Watchdog:
  - stall_cnt increments on stall cycles and saturates at 255.
  - Any non-stall cycle clears it.
  - When a stall cycle occurs with stall_cnt == STALL_MAX-1, stall_timeout sets at the next edge and stays set until reset.
  - The watchdog does not change any fetch-stage output.

## Timing
- Zero-latency decisions: outputs reflect the same-cycle inputs. State updates on the rising edge of clk.
- While rst_n is low:
  - All registers clear: exc_pending=0, holdoff_cnt=0, stall_cnt=0, stall_timeout=0.
  - Outputs are forced to PC_IF_ID_Write=0, select=000, status=00, irq_ack=0.
- Reset deassertion: the first cycle after reset is an ordinary case-6 cycle unless an input event is present.
- Reset mid-operation drops any pending exception and any running holdoff.
- An exception arriving during a stall is latched and taken on the first cycle that is not a branch, stall or jump cycle, with status=01.
- irq and exception in the same eligible cycle: the exception is taken; irq waits for holdoff_cnt to expire.
- select_PC_next and status are never both nonzero.
- PC_IF_ID_Write=0 only occurs with select=000.

## Test plan
- Reset, then idle: write=1, select=000, status=00 each cycle; all flags 0.
- load_use_hazard high 2 cycles with jump_id high: write=0 and select=000 for 2 cycles, then select=010 with write=1.
- exception pulse coincident with branch_taken: that cycle select=100 and exc_pending=1. Next idle cycle status=01, then exc_pending=0.
- irq held high with kernel_mode=0 and HOLDOFF=3: irq_ack on cycle 0, status=00 on cycles 1-3, next irq_ack on cycle 4. With kernel_mode=1 there is no ack at all.
- irq and exception together: status=01 first, no irq_ack for the next 3 cycles.
- load_use_hazard held with STALL_MAX=15: stall_timeout rises after the 15th stall cycle and stays 1 after the hazard clears; rst_n pulse clears it.
